// File: rtl/alu_issue_unit.sv
// Issue stage for a 4-bit-control ALU: decodes one MIPS-subset instruction per handshake,
// drives the ALU and returns the captured result. Optional macro ALU_ISSUE_OVERLAP_EN removes the IDLE bubble.
`timescale 1ns/1ps
module alu_issue_unit #(
    parameter int DW   = 32,
    parameter int IMMW = 16
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic            w_in_valid,
    output logic            r_in_ready,
    input  logic [5:0]      w_op,
    input  logic [5:0]      w_funct,
    input  logic [DW-1:0]   w_rs_val,
    input  logic [DW-1:0]   w_rt_val,
    input  logic [IMMW-1:0] w_imm,
    output logic [3:0]      r_alu_ctl,
    output logic [DW-1:0]   r_alu_a,
    output logic [DW-1:0]   r_alu_b,
    input  logic [DW-1:0]   w_alu_out,
    input  logic            w_alu_zero,
    output logic            r_out_valid,
    input  logic            w_out_ready,
    output logic [DW-1:0]   r_result,
    output logic            r_taken,
    output logic            r_illegal
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t          state_q, state_d;
    logic            alive_q, alive_d;
    logic [3:0]      alu_ctl_q, alu_ctl_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [DW-1:0]   result_q, result_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;
    logic            is_beq_q, is_beq_d;
    logic            is_bne_q, is_bne_d;

    logic [3:0]      dec_ctl;
    logic            dec_legal;
    logic            dec_use_imm;
    logic            dec_sext;
    logic            dec_beq;
    logic            dec_bne;
    logic [DW-1:0]   imm_sext;
    logic [DW-1:0]   imm_zext;
    logic [DW-1:0]   dec_b;
    logic            in_ready;
    logic            accept;

    assign imm_sext = {{(DW-IMMW){w_imm[IMMW-1]}}, w_imm};
    assign imm_zext = {{(DW-IMMW){1'b0}}, w_imm};

    always_comb begin
        dec_ctl     = 4'd0;
        dec_legal   = 1'b1;
        dec_use_imm = 1'b0;
        dec_sext    = 1'b1;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h24:   dec_ctl = 4'd0;
                    6'h25:   dec_ctl = 4'd1;
                    6'h20:   dec_ctl = 4'd2;
                    6'h22:   dec_ctl = 4'd6;
                    6'h2A:   dec_ctl = 4'd7;
                    6'h27:   dec_ctl = 4'd12;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_ctl = 4'd2; dec_use_imm = 1'b1; end
            6'h0A: begin dec_ctl = 4'd7; dec_use_imm = 1'b1; end
            6'h0C: begin dec_ctl = 4'd0; dec_use_imm = 1'b1; dec_sext = 1'b0; end
            6'h0D: begin dec_ctl = 4'd1; dec_use_imm = 1'b1; dec_sext = 1'b0; end
            6'h23, 6'h2B: begin dec_ctl = 4'd2; dec_use_imm = 1'b1; end
            6'h04: begin dec_ctl = 4'd6; dec_beq = 1'b1; end
            6'h05: begin dec_ctl = 4'd6; dec_bne = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_b = dec_use_imm ? (dec_sext ? imm_sext : imm_zext) : w_rt_val;

    // alive_q keeps ready low until the first edge after reset release.
`ifdef ALU_ISSUE_OVERLAP_EN
    assign in_ready = alive_q & ((state_q == IDLE) | ((state_q == DONE) & w_out_ready));
`else
    assign in_ready = alive_q & (state_q == IDLE);
`endif
    assign accept = w_in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        alive_d   = 1'b1;
        alu_ctl_d = alu_ctl_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        result_d  = result_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        is_beq_d  = is_beq_q;
        is_bne_d  = is_bne_q;
        case (state_q)
            ISSUE: begin
                result_d  = w_alu_out;
                taken_d   = (is_beq_q & w_alu_zero) | (is_bne_q & ~w_alu_zero);
                illegal_d = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                if (w_out_ready) state_d = IDLE;
            end
            default: ;
        endcase
        // An accept in DONE (overlap build) takes priority over the return to IDLE.
        if (accept) begin
            alu_a_d = w_rs_val;
            if (dec_legal) begin
                alu_ctl_d = dec_ctl;
                alu_b_d   = dec_b;
                is_beq_d  = dec_beq;
                is_bne_d  = dec_bne;
                state_d   = ISSUE;
            end else begin
                alu_ctl_d = 4'd15;
                alu_b_d   = w_rt_val;
                is_beq_d  = 1'b0;
                is_bne_d  = 1'b0;
                result_d  = '0;
                taken_d   = 1'b0;
                illegal_d = 1'b1;
                state_d   = DONE;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q   <= IDLE;
            alive_q   <= 1'b0;
            alu_ctl_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            is_beq_q  <= 1'b0;
            is_bne_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            alive_q   <= alive_d;
            alu_ctl_q <= alu_ctl_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            result_q  <= result_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            is_beq_q  <= is_beq_d;
            is_bne_q  <= is_bne_d;
        end
    end

    assign r_in_ready  = in_ready;
    assign r_out_valid = (state_q == DONE);
    assign r_alu_ctl   = alu_ctl_q;
    assign r_alu_a     = alu_a_q;
    assign r_alu_b     = alu_b_q;
    assign r_result    = result_q;
    assign r_taken     = taken_q;
    assign r_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: a reference ALU drives w_alu_out, and a scoreboard of
// expected results is filled on each accept and checked on each result handoff.
`timescale 1ns/1ps
module tb_alu_issue_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        taken;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        logic        il;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;
    int     n_ho  = 0;
    longint last_ho = 0;
    longint prev_ho = 0;
    longint vstart  = 0;
    logic   ov_prev = 1'b0;

    alu_issue_unit #(.DW(32), .IMMW(16)) dut (
        .w_clk       (clk),
        .w_rst_n     (rst_n),
        .w_in_valid  (in_valid),
        .r_in_ready  (in_ready),
        .w_op        (op),
        .w_funct     (funct),
        .w_rs_val    (rs_val),
        .w_rt_val    (rt_val),
        .w_imm       (imm),
        .r_alu_ctl   (alu_ctl),
        .r_alu_a     (alu_a),
        .r_alu_b     (alu_b),
        .w_alu_out   (alu_out),
        .w_alu_zero  (alu_zero),
        .r_out_valid (out_valid),
        .w_out_ready (out_ready),
        .r_result    (result),
        .r_taken     (taken),
        .r_illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; its SLT is an unsigned compare.
    always_comb begin
        alu_out = 32'h0;
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = {31'h0, alu_a < alu_b};
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'h0;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    function automatic exp_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [15:0] i);
        exp_t e;
        logic [31:0] se;
        logic [31:0] ze;
        se = {{16{i[15]}}, i};
        ze = {16'h0, i};
        e.res = 32'h0; e.tk = 1'b0; e.il = 1'b0; e.acc = 0;
        case (o)
            6'h00: case (f)
                6'h24:   e.res = a & b;
                6'h25:   e.res = a | b;
                6'h20:   e.res = a + b;
                6'h22:   e.res = a - b;
                6'h2A:   e.res = (a < b) ? 32'd1 : 32'd0;
                6'h27:   e.res = ~(a | b);
                default: e.il = 1'b1;
            endcase
            6'h08, 6'h23, 6'h2B: e.res = a + se;
            6'h0A: e.res = (a < se) ? 32'd1 : 32'd0;
            6'h0C: e.res = a & ze;
            6'h0D: e.res = a | ze;
            6'h04: begin e.res = a - b; e.tk = (a == b); end
            6'h05: begin e.res = a - b; e.tk = (a != b); end
            default: e.il = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, settle scoreboard #1 after it.
    task automatic cycle();
        logic        fi;
        logic        fo;
        logic [31:0] o_res;
        logic        o_tk;
        logic        o_il;
        longint      t_start;
        exp_t        e;
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        o_res = result; o_tk = taken; o_il = illegal;
        t_start = $time;
        @(posedge clk); #1;
        if (fo) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", o_res, e.res);
                chk("taken", {31'h0, o_tk}, {31'h0, e.tk});
                chk("illegal", {31'h0, o_il}, {31'h0, e.il});
                // Cycles from the start of the accepting cycle to first valid: 2 legal, 1 illegal.
                chk("latency", 32'((vstart - e.acc) / 10), e.il ? 32'd1 : 32'd2);
            end
            prev_ho = last_ho;
            last_ho = $time;
            n_ho++;
        end
        if (out_valid && (!ov_prev || fo)) vstart = $time;
        ov_prev = out_valid;
        if (fi) begin
            e = model(op, funct, rs_val, rt_val, imm);
            e.acc = t_start;
            sb.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] i);
        int n;
        op = o; funct = f; rs_val = a; rt_val = b; imm = i;
        in_valid = 1'b1;
        n = 0;
        while (in_valid && n < 20) begin
            cycle();
            n++;
        end
        if (in_valid) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {28'h0, alu_ctl}, 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'h0, taken, illegal, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", {31'h0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // ADD 1+2, operands visible during ISSUE
        send(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
        chk("add_ctl", {28'h0, alu_ctl}, 32'd2);
        chk("add_a", alu_a, 32'd1);
        chk("add_b", alu_b, 32'd2);
        chk("add_issue_not_valid", {31'h0, out_valid}, 32'd0);
        drain();

        // Immediate extension
        send(6'h08, 6'h00, 32'h10, 32'h0, 16'hFFFF);
        chk("addi_b_sext", alu_b, 32'hFFFF_FFFF);
        drain();
        send(6'h0D, 6'h00, 32'h1, 32'h0, 16'h8000);
        chk("ori_b_zext", alu_b, 32'h0000_8000);
        drain();
        send(6'h0A, 6'h00, 32'h5, 32'h0, 16'hFFFF);
        drain();
        send(6'h23, 6'h00, 32'h100, 32'h0, 16'hFFFC);
        drain();

        // Branches with equal operands
        send(6'h04, 6'h00, 32'd2, 32'd2, 16'h0);
        chk("beq_ctl", {28'h0, alu_ctl}, 32'd6);
        drain();
        send(6'h05, 6'h00, 32'd2, 32'd2, 16'h0);
        drain();
        send(6'h05, 6'h00, 32'd2, 32'd9, 16'h0);
        drain();

        // Illegal opcode and funct go straight to DONE
        send(6'h3F, 6'h00, 32'd4, 32'd4, 16'h0);
        chk("ill_valid_early", {31'h0, out_valid}, 32'd1);
        chk("ill_ctl", {28'h0, alu_ctl}, 32'd15);
        chk("ill_flag", {31'h0, illegal}, 32'd1);
        chk("ill_result", result, 32'd0);
        drain();
        send(6'h00, 6'h21, 32'd4, 32'd4, 16'h0);
        drain();

        // Backpressure on NOR 0,0
        out_ready = 1'b0;
        send(6'h00, 6'h27, 32'd0, 32'd0, 16'h0);
        n = 0;
        while (!out_valid && n < 10) begin cycle(); n++; end
        in_valid = 1'b1; op = 6'h00; funct = 6'h20; rs_val = 32'd7; rt_val = 32'd7;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_result", result, 32'hFFFF_FFFF);
            chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
            cycle();
        end
        in_valid = 1'b0;
        chk("bp_not_queued", sb.size(), 32'd1);
        h0 = n_ho;
        out_ready = 1'b1;
        cycle();
        chk("bp_one_handoff", n_ho, h0 + 1);
        chk("bp_valid_drop", {31'h0, out_valid}, 32'd0);
        cycle(); cycle();
        chk("bp_no_extra", n_ho, h0 + 1);

        // Reset during ISSUE discards the instruction
        send(6'h00, 6'h20, 32'd7, 32'd8, 16'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ctl_a_b", {28'h0, alu_ctl} | alu_a | alu_b, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_flags", {28'h0, taken, illegal, out_valid, in_ready}, 32'd0);
        sb.delete();
        ov_prev = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        h0 = n_ho;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("no_valid_after_rst", {31'h0, out_valid}, 32'd0);
        end
        chk("no_handoff_after_rst", n_ho, h0);

        // Back-to-back SUB then SLT
        send(6'h00, 6'h22, 32'd5, 32'd3, 16'h0);
        send(6'h00, 6'h2A, 32'd1, 32'd2, 16'h0);
        drain();
        chk("b2b_handoffs", n_ho, h0 + 2);
`ifdef ALU_ISSUE_OVERLAP_EN
        chk("b2b_interval", 32'((last_ho - prev_ho) / 10), 32'd2);
`else
        chk("b2b_interval", 32'((last_ho - prev_ho) / 10), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
Producer side of the 4-bit-control ALU interface (ctl, A, B -> Out, Zero). Accepts one decoded MIPS-subset instruction per valid/ready handshake and maps opcode/funct to an ALU control code. Selects operand B (register or extended immediate), drives the ALU, and captures Out/Zero one cycle later. Returns result, branch decision and an illegal-instruction flag on an output valid/ready handshake. Sits between the operand-read stage and writeback/branch logic of the multi-cycle datapath.

Parameters:
- DW, 32, datapath width; applies to operands, ALU ports and result.
- IMMW, 16, immediate width; extended to DW.

Ports:
- w_clk  in  1  clock; all state changes on the rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_in_valid  in  1  instruction offered.
- r_in_ready  out  1  unit can accept an instruction.
- w_op  in  6  opcode.
- w_funct  in  6  funct field; used only when op=0.
- w_rs_val  in  DW  rs operand.
- w_rt_val  in  DW  rt operand.
- w_imm  in  IMMW  immediate.
- r_alu_ctl  out  4  ALU control code.
- r_alu_a  out  DW  ALU operand A.
- r_alu_b  out  DW  ALU operand B.
- w_alu_out  in  DW  ALU result.
- w_alu_zero  in  1  ALU zero flag.
- r_out_valid  out  1  result available.
- w_out_ready  in  1  consumer accepts the result.
- r_result  out  DW  captured ALU result.
- r_taken  out  1  branch taken; 0 for non-branches.
- r_illegal  out  1  unsupported op/funct.

Behaviour:
- Reset (w_rst_n=0, asynchronous):
  - state=IDLE.
  - r_alu_ctl, r_alu_a, r_alu_b, r_result, r_taken, r_illegal, r_out_valid all 0.
  - r_in_ready=0 while reset is asserted; 1 from the first cycle after release.
  - Reset mid-operation discards the in-flight instruction; no r_out_valid is produced for it.
- Decode, R-type (op=0x00), operand B = rt:
  - funct 0x24 AND -> ctl 0
  - funct 0x25 OR -> ctl 1
  - funct 0x20 ADD -> ctl 2
  - funct 0x22 SUB -> ctl 6
  - funct 0x2A SLT -> ctl 7
  - funct 0x27 NOR -> ctl 12
  - any other funct -> illegal.
- Decode, I-type, operand B = extended immediate:
  - ADDI 0x08 -> ctl 2, sign-extended.
  - SLTI 0x0A -> ctl 7, sign-extended.
  - ANDI 0x0C -> ctl 0, zero-extended.
  - ORI 0x0D -> ctl 1, zero-extended.
  - LW 0x23 and SW 0x2B -> ctl 2, sign-extended (address add).
- Decode, branches, operand B = rt:
  - BEQ 0x04 -> ctl 6; r_taken = w_alu_zero.
  - BNE 0x05 -> ctl 6; r_taken = ~w_alu_zero.
- Operand A = rs for every opcode.
- Any other opcode -> illegal.
- The unit does not reinterpret the result. The ALU's SLT compare is unsigned and r_result carries it unchanged.
- FSM:
  - IDLE: r_in_ready=1. On w_in_valid & r_in_ready, decode and register ctl/A/B into r_alu_*.
    - Legal -> ISSUE.
    - Illegal -> DONE with r_result=0, r_taken=0, r_illegal=1, r_alu_ctl=15.
  - ISSUE: r_alu_* held stable for exactly one cycle (ALU settle). At the ending edge, capture r_result=w_alu_out and compute r_taken; r_illegal=0; -> DONE.
  - DONE: r_out_valid=1. Outputs held stable until w_out_ready=1; at that edge -> IDLE and r_out_valid=0.
- Latency (legal instruction): accepted at edge k -> r_out_valid=1 from edge k+2. Illegal: r_out_valid=1 from edge k+1.
- Backpressure: w_out_ready low holds DONE indefinitely with r_result, r_taken, r_illegal, r_alu_* unchanged.
- r_in_ready=0 in ISSUE and DONE. w_in_valid during those states is ignored and not queued.
- r_alu_* keep their last values in IDLE; they are not cleared.

Optional Feature:
ALU_ISSUE_OVERLAP_EN
- Defined:
  - r_in_ready = IDLE | (DONE & w_out_ready).
  - An accept in DONE coincident with a result handoff moves directly to ISSUE (or to DONE with new illegal values), removing the IDLE bubble.
  - Back-to-back legal throughput is 1 instruction per 2 cycles.
- Undefined: r_in_ready only in IDLE; throughput is 1 per 3 cycles.

Test Plan:
1. ADD: op=0, funct=0x20, rs=1, rt=2.
   - ISSUE cycle: r_alu_ctl=2, A=1, B=2.
   - r_result=3 at k+2.
   - r_taken=0, r_illegal=0.
2. ADDI sign extension: op=0x08, rs=0x10, imm=0xFFFF.
   - B=0xFFFFFFFF, r_result=0x0000000F.
   - ORI with imm=0x8000 gives B=0x00008000.
3. BEQ then BNE with rs=rt=2.
   - BEQ: ctl=6, r_result=0, r_taken=1.
   - BNE with the same operands: r_taken=0.
4. Illegal op=0x3F.
   - r_out_valid at k+1, r_illegal=1, r_result=0, r_alu_ctl=15.
   - ISSUE state never entered.
5. Backpressure: hold w_out_ready=0 for 5 cycles after NOR rs=0, rt=0.
   - r_result=0xFFFFFFFF held stable throughout.
   - r_in_ready=0 throughout.
   - Single handoff when w_out_ready rises.
6. Reset and back-to-back traffic:
   - Assert w_rst_n=0 during ISSUE: all outputs 0 immediately, no r_out_valid after release.
   - Then issue SUB 5-3 followed by SLT 1<2: results 2 and 1.
   - Handoff edge to next result is 3 cycles without ALU_ISSUE_OVERLAP_EN, 2 cycles with it.
